text_term_ctrl: RTL and testbench
=================================

# text_term_ctrl

Terminal-style write controller for the VGA text-mode character buffer. Accepts ASCII codes from the PS/2 decode path, keeps the cursor, interprets LF/CR/BS, and issues all writes into the 4096×8 character RAM, including power-up clear, explicit clear-screen and line clear on scroll. Also exports a circular row base so the display read side can scroll without copying memory.

## Interface
- COLS, 70, characters per line
- ROWS, 30, lines per screen
- FIFO_DEPTH, 4, key buffer entries (power of two)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- key_valid  in  1  ASCII code present on key_data
- key_data  in  8  ASCII code
- key_ready  out  1  FIFO can accept; transfer on key_valid && key_ready at posedge
- clr_req  in  1  single-cycle pulse: clear screen, home cursor
- wr_en  out  1  character RAM write strobe
- wr_addr  out  12  {phys_row[4:0], col[6:0]}
- wr_data  out  8  byte to write
- row_base  out  5  physical row holding logical line 0
- cur_x  out  7  cursor column, 0..COLS-1
- cur_y  out  5  cursor logical line, 0..ROWS-1
- busy  out  1  high in CLR_ALL or CLR_LINE

## Operation
- States: CLR_ALL, IDLE, CLR_LINE.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, row_base 0, cur_x 0, cur_y 0, busy 1, key_ready 0, FIFO empty, state CLR_ALL, sweep counter 0.
- CLR_ALL: one write per cycle, wr_data 0x00, wr_addr 0..4095 ascending; after 4095 → IDLE, busy 0.
- IDLE: clr_req (latched in pending flag, also latched while busy) has priority: flush FIFO, cur/row_base ← 0, → CLR_ALL. Otherwise, if FIFO non-empty, pop one code per cycle.
- phys_row = row_base + cur_y, minus ROWS if ≥ ROWS (6-bit intermediate).
- 0x20..0x7E: write code at (phys_row, cur_x); if cur_x == COLS-1 do newline, else cur_x+1.
- 0x0A or 0x0D: newline, no write.
- 0x08: cur_x > 0 → cur_x-1, write 0x20 there; cur_x == 0 && cur_y > 0 → cur_y-1, cur_x = COLS-1, write 0x20 there; (0,0) → no-op.
- Any other code: dropped, no write, cursor unchanged.
- Newline: cur_x ← 0; if cur_y < ROWS-1, cur_y+1; else scroll: cur_y stays ROWS-1, row_base ← (row_base+1) mod ROWS, → CLR_LINE on the old row_base physical row (the new last line).
- CLR_LINE: COLS writes of 0x00, col 0..COLS-1, → IDLE. No FIFO pops while busy.
- key_ready = !fifo_full && !reset; FIFO continues accepting while busy.

## Timing
- Handshake at edge t, FIFO empty, IDLE: popped at edge t+1; wr_en high in the cycle after edge t+1 (registered outputs). Sustained 1 char/cycle.
- Printable at last column on last line: char write cycle, then row_base updates with the same edge, CLR_LINE writes start next cycle; line clear = COLS cycles.
- CLR_ALL = 4096 cycles; busy deasserts on the edge after the last write.
- clr_req during CLR_LINE: line finishes, then CLR_ALL. clr_req during CLR_ALL: one extra full sweep.
- Simultaneous push and pop with FIFO full: push refused (key_ready already 0).
- reset mid-operation: all state to reset values next edge, sweep restarts at 0.

## Structure
- Package text_term_pkg: COLS/ROWS defaults, ASCII_LF/CR/BS/SPACE constants, state enum, address-width localparams.
- Sub-module key_fifo: synchronous FIFO, width 8, FIFO_DEPTH, with push/pop/full/empty/flush.

## Test plan
- Reset, run 4096 cycles → 4096 writes of 0x00 at addrs 0..4095, busy then 0, key_ready 1.
- Send "AB" → writes 0x41 @0x000, 0x42 @0x001; cur_x 2.
- Send 70 × 'x' → last write at col 69 row 0, then cur_x 0, cur_y 1.
- Cursor at (0,1), send 0x08 → write 0x20 @ {row 0, col 69}; cur (69,0); 0x08 at (0,0) → no write.
- Fill to line 29, send 0x0A → row_base 1, 70 writes of 0x00 to phys row 0, cur (0,29); next 'Z' written @ {row 0, col 0}.
- Hold key_valid with 6 codes during CLR_LINE → 4 accepted, key_ready 0 until pops resume; clr_req mid-stream flushes FIFO, cursor/row_base 0, full sweep.

Source files
------------

// File: rtl/text_term_pkg.sv
// Shared constants, state encoding and row-mapping helper for the text terminal write controller.
package text_term_pkg;

    localparam int unsigned DEF_COLS       = 70;
    localparam int unsigned DEF_ROWS       = 30;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = ADDR_W;

    localparam logic [DATA_W-1:0] ASCII_BS    = 8'h08;
    localparam logic [DATA_W-1:0] ASCII_LF    = 8'h0A;
    localparam logic [DATA_W-1:0] ASCII_CR    = 8'h0D;
    localparam logic [DATA_W-1:0] ASCII_SPACE = 8'h20;
    localparam logic [DATA_W-1:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLR_ALL  = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CLR_LINE = 2'd2
    } state_t;

    // Logical line -> physical RAM row for a circular buffer of `rows` lines.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] base,
                                                  input logic [ROW_W-1:0] line,
                                                  input int unsigned      rows);
        logic [ROW_W:0] sum;
        sum = {1'b0, base} + {1'b0, line};
        if (sum >= (ROW_W+1)'(rows)) begin
            sum = sum - (ROW_W+1)'(rows);
        end
        return sum[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/text_term_ctrl_key_fifo.sv
// Small synchronous key FIFO; flush empties it while still taking a same-cycle push.
module key_fifo
    import text_term_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal-style writer for the text-mode character RAM: cursor, LF/CR/BS handling,
// power-up/explicit screen clear and circular scroll with per-line clear.
module text_term_ctrl
    import text_term_pkg::*;
#(
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_data,
    output logic              key_ready,
    input  logic              clr_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ROW_W-1:0]  row_base,
    output logic [COL_W-1:0]  cur_x,
    output logic [ROW_W-1:0]  cur_y,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_wr_en,    w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr,  w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data,  w_wr_data_nxt;
    logic [ROW_W-1:0]  r_row_base, w_row_base_nxt;
    logic [COL_W-1:0]  r_cur_x,    w_cur_x_nxt;
    logic [ROW_W-1:0]  r_cur_y,    w_cur_y_nxt;
    logic [ROW_W-1:0]  r_line_row, w_line_row_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic              r_clr_pend, w_clr_pend_nxt;
    logic              r_busy,     w_busy_nxt;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_clr;
    logic              w_is_print;
    logic              w_is_nl;
    logic              w_is_bs;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_newline;
    logic              w_scroll;
    logic              w_sweep_done;
    logic              w_line_done;
    logic [ROW_W-1:0]  w_phys_cur;
    logic [ROW_W-1:0]  w_phys_prev;

    key_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (key_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign key_ready = !w_fifo_full && !reset;
    assign w_push    = key_valid && key_ready;

    // A clear request seen in IDLE wins over any queued key.
    assign w_clr   = r_clr_pend || clr_req;
    assign w_flush = (r_state == ST_IDLE) && w_clr;
    assign w_pop   = (r_state == ST_IDLE) && !w_clr && !w_fifo_empty;

    assign w_is_print   = (w_fifo_data >= ASCII_SPACE) && (w_fifo_data <= ASCII_TILDE);
    assign w_is_nl      = (w_fifo_data == ASCII_LF) || (w_fifo_data == ASCII_CR);
    assign w_is_bs      = (w_fifo_data == ASCII_BS);
    assign w_last_col   = (r_cur_x == COL_W'(COLS - 1));
    assign w_last_row   = (r_cur_y == ROW_W'(ROWS - 1));
    assign w_newline    = w_pop && (w_is_nl || (w_is_print && w_last_col));
    assign w_scroll     = w_newline && w_last_row;
    assign w_sweep_done = (r_cnt == {CNT_W{1'b1}});
    assign w_line_done  = (r_cnt == CNT_W'(COLS - 1));
    assign w_phys_cur   = phys_row(r_row_base, r_cur_y, ROWS);
    assign w_phys_prev  = phys_row(r_row_base, r_cur_y - ROW_W'(1), ROWS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLR_ALL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLR_ALL: begin
                if (w_sweep_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_clr) begin
                    w_state_nxt = ST_CLR_ALL;
                end else if (w_scroll) begin
                    w_state_nxt = ST_CLR_LINE;
                end
            end
            ST_CLR_LINE: begin
                if (w_line_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_CLR_ALL;
        endcase
    end

    // busy follows the state one edge late so it brackets exactly the clear writes.
    always_comb begin
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_row_base_nxt = r_row_base;
        w_cur_x_nxt    = r_cur_x;
        w_cur_y_nxt    = r_cur_y;
        w_line_row_nxt = r_line_row;
        w_cnt_nxt      = r_cnt;
        w_clr_pend_nxt = r_clr_pend || clr_req;
        w_busy_nxt     = (r_state != ST_IDLE);

        case (r_state)
            ST_CLR_ALL: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = ADDR_W'(r_cnt);
                w_wr_data_nxt = '0;
                w_cnt_nxt     = r_cnt + CNT_W'(1);
            end
            ST_IDLE: begin
                if (w_clr) begin
                    w_clr_pend_nxt = 1'b0;
                    w_cur_x_nxt    = '0;
                    w_cur_y_nxt    = '0;
                    w_row_base_nxt = '0;
                    w_cnt_nxt      = '0;
                end else if (w_pop) begin
                    if (w_is_print) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = {w_phys_cur, r_cur_x};
                        w_wr_data_nxt = w_fifo_data;
                        if (!w_last_col) begin
                            w_cur_x_nxt = r_cur_x + COL_W'(1);
                        end
                    end else if (w_is_bs) begin
                        if (r_cur_x != '0) begin
                            w_cur_x_nxt   = r_cur_x - COL_W'(1);
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = {w_phys_cur, r_cur_x - COL_W'(1)};
                            w_wr_data_nxt = ASCII_SPACE;
                        end else if (r_cur_y != '0) begin
                            w_cur_y_nxt   = r_cur_y - ROW_W'(1);
                            w_cur_x_nxt   = COL_W'(COLS - 1);
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = {w_phys_prev, COL_W'(COLS - 1)};
                            w_wr_data_nxt = ASCII_SPACE;
                        end
                    end
                    if (w_newline) begin
                        w_cur_x_nxt = '0;
                        if (!w_last_row) begin
                            w_cur_y_nxt = r_cur_y + ROW_W'(1);
                        end else begin
                            // Old top line becomes the new bottom line and must be blanked.
                            w_row_base_nxt = (r_row_base == ROW_W'(ROWS - 1)) ? '0
                                                                              : r_row_base + ROW_W'(1);
                            w_line_row_nxt = r_row_base;
                            w_cnt_nxt      = '0;
                        end
                    end
                end
            end
            ST_CLR_LINE: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = {r_line_row, COL_W'(r_cnt)};
                w_wr_data_nxt = '0;
                w_cnt_nxt     = w_line_done ? '0 : r_cnt + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_row_base <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_line_row <= '0;
            r_cnt      <= '0;
            r_clr_pend <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_row_base <= w_row_base_nxt;
            r_cur_x    <= w_cur_x_nxt;
            r_cur_y    <= w_cur_y_nxt;
            r_line_row <= w_line_row_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clr_pend <= w_clr_pend_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign row_base = r_row_base;
    assign cur_x    = r_cur_x;
    assign cur_y    = r_cur_y;
    assign busy     = r_busy;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Scoreboard bench for text_term_ctrl: a terminal model queues expected RAM writes as keys are accepted.
module tb_text_term_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_ready;
    logic        clr_req;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  row_base;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    text_term_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .clr_req   (clr_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .row_base  (row_base),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [19:0] sb_q[$];
    logic [19:0] mon_exp;
    int          m_x, m_y, m_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Every observed RAM write must be the next entry of the expected stream.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check("wr_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check("wr_addr_data", {12'h0, wr_addr, wr_data}, {12'h0, mon_exp});
            end
        end
    end

    function automatic int m_phys(input int line);
        int s;
        s = m_base + line;
        if (s >= ROWS) s = s - ROWS;
        return s;
    endfunction

    function automatic void exp_wr(input int row, input int col, input logic [7:0] d);
        sb_q.push_back({5'(row), 7'(col), d});
    endfunction

    function automatic void model_clear();
        m_x = 0; m_y = 0; m_base = 0;
        for (int i = 0; i < 4096; i++) sb_q.push_back({12'(i), 8'h00});
    endfunction

    function automatic void model_newline();
        int old;
        m_x = 0;
        if (m_y < ROWS - 1) m_y++;
        else begin
            old    = m_base;
            m_base = (m_base + 1) % ROWS;
            for (int c = 0; c < COLS; c++) exp_wr(old, c, 8'h00);
        end
    endfunction

    function automatic void model_key(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_wr(m_phys(m_y), m_x, c);
            if (m_x == COLS - 1) model_newline();
            else m_x++;
        end else if (c == 8'h0A || c == 8'h0D) begin
            model_newline();
        end else if (c == 8'h08) begin
            if (m_x > 0) begin
                m_x--;
                exp_wr(m_phys(m_y), m_x, 8'h20);
            end else if (m_y > 0) begin
                m_y--;
                m_x = COLS - 1;
                exp_wr(m_phys(m_y), m_x, 8'h20);
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge, key_valid left high.
    task automatic send_key(input logic [7:0] c, input bit modeled, output int waited);
        key_valid = 1'b1;
        key_data  = c;
        waited    = 0;
        while (key_ready !== 1'b1 && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        check("key_ready_wait", 32'(key_ready), 1);
        if (modeled) model_key(c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        int w;
        send_key(c, 1'b1, w);
    endtask

    task automatic send_n(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) send(c);
        key_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        key_valid = 1'b0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_busy_low(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_low", 32'(busy), 0);
    endtask

    task automatic check_cursor(input string tag, input int ex, input int ey, input int eb);
        check({tag, "_cur_x"}, 32'(cur_x), 32'(ex));
        check({tag, "_cur_y"}, 32'(cur_y), 32'(ey));
        check({tag, "_row_base"}, 32'(row_base), 32'(eb));
        check({tag, "_model_x"}, 32'(cur_x), 32'(m_x));
        check({tag, "_model_base"}, 32'(row_base), 32'(m_base));
    endtask

    initial begin
        int w;
        int wsum;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        clr_req   = 1'b0;
        m_x = 0; m_y = 0; m_base = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_key_ready", 32'(key_ready), 0);
        check("rst_cur_x", 32'(cur_x), 0);
        check("rst_cur_y", 32'(cur_y), 0);
        check("rst_row_base", 32'(row_base), 0);

        // Power-up sweep of the whole RAM.
        model_clear();
        reset = 1'b0;
        wait_busy_low(5000);
        check("sweep_done", 32'(sb_q.size()), 0);
        check("post_sweep_key_ready", 32'(key_ready), 1);

        // "AB" with first-character latency and back-to-back throughput.
        model_key(8'h41);
        model_key(8'h42);
        key_valid = 1'b1;
        key_data  = 8'h41;
        @(posedge clk);
        @(negedge clk);
        check("lat_edge_t", 32'(wr_en), 0);
        key_data = 8'h42;
        @(posedge clk);
        @(negedge clk);
        check("lat_edge_t1", 32'(wr_en), 1);
        key_valid = 1'b0;
        @(negedge clk);
        check("sustained", 32'(wr_en), 1);
        wait_drain(100);
        check_cursor("ab", 2, 0, 0);

        // Backspace back to home, then a full line wraps to line 1.
        send(8'h08);
        send(8'h08);
        send_n(8'h78, COLS);
        wait_drain(200);
        check_cursor("wrap", 0, 1, 0);

        // Backspace across the line boundary, then down to the (0,0) no-op.
        send_n(8'h08, 1);
        wait_drain(100);
        check_cursor("bs_wrap", 69, 0, 0);
        send_n(8'h08, 69);
        send(8'h08);
        send(8'h07);
        send(8'h7F);
        send(8'h00);
        send(8'hC1);
        wait_drain(200);
        check_cursor("bs_home", 0, 0, 0);

        // Fill to the last line, then scroll via LF and via a last-column character.
        send_n(8'h0A, ROWS - 1);
        wait_drain(200);
        check_cursor("line29", 0, 29, 0);
        send_n(8'h0A, 1);
        wait_drain(200);
        check_cursor("scroll_lf", 0, 29, 1);
        send(8'h5A);
        send_n(8'h79, COLS - 1);
        wait_drain(400);
        check_cursor("scroll_char", 0, 29, 2);

        // Keys pile up during a line clear, then two clears flush them.
        send(8'h0A);
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            send_key(8'h61 + 8'(i), 1'b0, w);
            wsum += w;
        end
        check("fifo_accept4", 32'(wsum), 0);
        check("fifo_full_ready", 32'(key_ready), 0);
        key_data = 8'h65;
        repeat (10) @(negedge clk);
        check("fifo_hold_ready", 32'(key_ready), 0);
        check("line_clr_busy", 32'(busy), 1);
        key_valid = 1'b0;
        clr_req   = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        model_clear();
        repeat (150) @(negedge clk);
        check("sweep1_busy", 32'(busy), 1);
        check("sweep1_cur_y", 32'(cur_y), 0);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        model_clear();
        wait_busy_low(9000);
        send(8'h65);
        send(8'h66);
        key_valid = 1'b0;
        wait_drain(9000);
        check_cursor("after_clr", 2, 0, 0);
        check("final_key_ready", 32'(key_ready), 1);
        check("final_busy", 32'(busy), 0);

        repeat (20) @(negedge clk);
        check("no_stray_writes", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
